sub_bytes_seq: RTL
==================

// Module: sub_bytes_seq
// PURPOSE
// - AES SubBytes stage placed directly upstream of the ShiftRow stage; its sm0..sm15 outputs drive ShiftRow's sm0..sm15 inputs.
// - Accepts one 128-bit AES state through a valid/ready handshake.
// - Substitutes the state through a shared S-box datapath, LANES bytes per cycle, and holds the result until taken.
// - Area/throughput trade-off is set by LANES.
// PARAMETERS
// - LANES  4  bytes substituted per cycle; legal values 1,2,4,8,16; N = 16/LANES processing cycles
// PORTS
// - sys_clk    input   1    single clock, all logic on rising edge
// - sys_rst_n  input   1    reset, synchronous, active-low
// - in_valid   input   1    state_in is valid
// - in_ready   output  1    block can accept a state
// - state_in   input   128  byte i = state_in[8*i+7:8*i], i = 0..15
// - out_valid  output  1    sm0..sm15 hold a complete substituted state
// - out_ready  input   1    downstream takes the result
// - sm0..sm15  output  8    substituted bytes; sm_i = S(byte i); registered
// BEHAVIOUR
// - Reset (sys_rst_n=0 at an edge): FSM=IDLE, cnt=0, out_valid=0, sm0..sm15=8'h00, in_ready=1 from the next cycle.
// - Reset mid-operation aborts the operation; the captured state is discarded and no out_valid is produced.
// - FSM IDLE -> BUSY: on an edge with in_valid & in_ready. Capture state_in into the work buffer; cnt=0.
// - FSM BUSY: each edge writes S(buf[k]) into sm_k for k = cnt*LANES .. cnt*LANES+LANES-1, then cnt++.
//   After the chunk with cnt = N-1, go to DONE and set out_valid=1.
// - FSM DONE: hold out_valid and sm0..sm15 stable while out_ready=0.
//   On an edge with out_ready=1, clear out_valid and go to IDLE.
// - in_ready = (FSM==IDLE); combinational from state only, with no path from in_valid/out_ready.
// - in_valid is ignored while in BUSY or DONE. A new accept occurs no earlier than the cycle after the DONE->IDLE edge (one bubble).
// - Latency: out_valid rises exactly N edges after the accepting edge (LANES=4 -> 4; LANES=16 -> 1).
// - sm outputs of bytes not yet processed keep their previous values during BUSY. Only the out_valid=1 contents are architecturally defined.
// - cnt width = clog2(N) (min 1), wraps to 0 only via accept. No arithmetic beyond the cnt increment.
// - out_ready asserted while not in DONE: no effect.
// CONFIGURATION
// - Macro SUBBYTES_INV_EN defined:
//   - Adds input port `inv` (1 bit), sampled on the accepting edge and held for the operation.
//   - inv=1 selects the inverse S-box (InvSubBytes, decryption path); inv=0 selects the forward S-box.
// - SUBBYTES_INV_EN undefined: `inv` port absent; forward S-box only; no inverse table synthesized.
// STRUCTURE
// - Package aes_pkg:
//   - AES_BYTES=16
//   - SBOX[256] and INV_SBOX[256] byte constant arrays (FIPS-197)
//   - sub_fsm_t enum {IDLE, BUSY, DONE}
// - Sub-module aes_sbox_lane: combinational 8-bit lookup with an inv select; instantiated LANES times.
// - Top module holds the FSM, cnt, the work buffer, and the output byte registers.
// TESTING
// - Reset: hold sys_rst_n=0 for 2 edges -> out_valid=0, sm0..sm15=00, in_ready=1.
// - LANES=4, byte i = i (00..0F), out_ready=1 -> out_valid after exactly 4 edges;
//   sm0=63, sm1=7C, sm2=77, sm3=7B, sm15=76.
// - Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and sm0..sm15 stable,
//   in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, next accept one cycle later.
// - Mid-op reset: accept state 53 x16, assert sys_rst_n=0 at BUSY cnt=2 -> out_valid never rises,
//   sm0..sm15=00; next state FF x16 -> all sm=16.
// - Back-to-back: 3 states with in_valid held high, out_ready=1 -> results in order,
//   one idle cycle between DONE and the next accept.
// - SUBBYTES_INV_EN: inv=1, all bytes 63 -> all sm=00; inv=1, all ED -> all sm=53;
//   inv toggled during BUSY has no effect.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: byte count, forward/inverse S-box tables (FIPS-197) and the SubBytes FSM encoding.
package aes_pkg;

    localparam int AES_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_fsm_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lookup lane. INV_EN=0 keeps the inverse table out of the netlist;
// INV_EN=1 lets `inv` choose between SubBytes and InvSubBytes.
module aes_sbox_lane
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b0
)
(
    input  logic [7:0] lane_byte,
    input  logic       inv,
    output logic [7:0] lane_sub
);

    // Table lookup; the inverse branch is statically dead unless INV_EN is set.
    always_comb begin
        lane_sub = 8'h00;
        if (INV_EN && inv) begin
            lane_sub = INV_SBOX[lane_byte];
        end else begin
            lane_sub = SBOX[lane_byte];
        end
    end

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: accepts one 128-bit state, substitutes LANES bytes per cycle, holds the result
// until taken. Define SUBBYTES_INV_EN to add the `inv` port and the inverse S-box (InvSubBytes).
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
)
(
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
`ifdef SUBBYTES_INV_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   sm0,
    output logic [7:0]   sm1,
    output logic [7:0]   sm2,
    output logic [7:0]   sm3,
    output logic [7:0]   sm4,
    output logic [7:0]   sm5,
    output logic [7:0]   sm6,
    output logic [7:0]   sm7,
    output logic [7:0]   sm8,
    output logic [7:0]   sm9,
    output logic [7:0]   sm10,
    output logic [7:0]   sm11,
    output logic [7:0]   sm12,
    output logic [7:0]   sm13,
    output logic [7:0]   sm14,
    output logic [7:0]   sm15
);

    localparam int N     = AES_BYTES / LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    sub_fsm_t         state_r;
    sub_fsm_t         state_next_s;
    logic             accept_s;
    logic [CNT_W-1:0] cnt_r;
    logic [127:0]     buf_r;
    logic             out_valid_r;
    logic [7:0]       sm_r [AES_BYTES];
    logic [7:0]       lane_sub_s [LANES];
    logic             inv_sel_s;

`ifdef SUBBYTES_INV_EN
    localparam bit INV_EN = 1'b1;
    logic inv_r;

    // Direction latched at accept so toggling `inv` mid-operation has no effect.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            inv_r <= 1'b0;
        end else if (accept_s) begin
            inv_r <= inv;
        end else begin
            inv_r <= inv_r;
        end
    end
    assign inv_sel_s = inv_r;
`else
    localparam bit INV_EN = 1'b0;
    assign inv_sel_s = 1'b0;
`endif

    // The buffer shifts down one chunk per cycle, so lane l always reads byte l of the buffer.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox_lane #(.INV_EN(INV_EN)) u_lane (
            .lane_byte (buf_r[8*l +: 8]),
            .inv       (inv_sel_s),
            .lane_sub  (lane_sub_s[l])
        );
    end

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and accept decode.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Work buffer, chunk counter, output valid and the substituted output bytes.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            buf_r       <= 128'h0;
            out_valid_r <= 1'b0;
            for (int k = 0; k < AES_BYTES; k++) begin
                sm_r[k] <= 8'h00;
            end
        end else begin
            out_valid_r <= (state_next_s == DONE);
            if (accept_s) begin
                buf_r <= state_in;
                cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == BUSY) begin
                buf_r <= buf_r >> (8 * LANES);
                cnt_r <= cnt_r + CNT_W'(1'b1);
                for (int k = 0; k < AES_BYTES; k++) begin
                    if (cnt_r == CNT_W'(k / LANES)) begin
                        sm_r[k] <= lane_sub_s[k % LANES];
                    end else begin
                        sm_r[k] <= sm_r[k];
                    end
                end
            end else begin
                buf_r <= buf_r;
                cnt_r <= cnt_r;
            end
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;

    assign sm0  = sm_r[0];
    assign sm1  = sm_r[1];
    assign sm2  = sm_r[2];
    assign sm3  = sm_r[3];
    assign sm4  = sm_r[4];
    assign sm5  = sm_r[5];
    assign sm6  = sm_r[6];
    assign sm7  = sm_r[7];
    assign sm8  = sm_r[8];
    assign sm9  = sm_r[9];
    assign sm10 = sm_r[10];
    assign sm11 = sm_r[11];
    assign sm12 = sm_r[12];
    assign sm13 = sm_r[13];
    assign sm14 = sm_r[14];
    assign sm15 = sm_r[15];

endmodule
